return_arbiter_rob: RTL and testbench

Return-path arbiter, successor to the current return arbiter. Collects return values from CHILD child function instances and delivers them per parent. It adds a per-parent reorder buffer (ROB): in IN_ORDER mode, returns are released to each parent in call-sequence order, whatever order the children complete in. It sits between the child function return ports and the parent return-FIFO pop interfaces.

---
 rtl/return_arbiter_rob.sv | 181 ++++++++++++++++++
 tb/tb_return_arbiter_rob.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/return_arbiter_rob.sv
// Return-path arbiter with a per-parent reorder buffer; one input buffer slot per child.
// Latency: handshake at edge E0, ROB write at E1 if uncontended, head visible the cycle after E1.
// Backpressure: child_retRdy_o drops while the child's buffer is occupied (stalled on a busy ROB slot or a lost arbitration).
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   child_retVld_i/Rdy_o       per-child return handshake
//   child_retDin_i             return value per child
//   child_parentMod_i          destination parent per child
//   child_retSeq_i             call sequence number, selects the ROB slot in IN_ORDER mode
//   parent_retFifo_pop_i       per-parent pop strobe
//   parent_retFifo_empty_n_o   head entry available per parent
//   parent_retFifo_dout_o      {child id, return value} at head per parent
//   err_o                      sticky flag: a return addressed to a nonexistent parent was dropped
module return_arbiter_rob #(
  parameter int PARENT   = 4,
  parameter int CHILD    = 4,
  parameter int RET_DW   = 32,
  parameter int SEQ_W    = 3,
  parameter int IN_ORDER = 1,
  localparam int LOG_PARENT = (PARENT > 1) ? $clog2(PARENT) : 1,
  localparam int LOG_CHILD  = (CHILD > 1) ? $clog2(CHILD) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CHILD-1:0]                         child_retVld_i,
  output logic [CHILD-1:0]                         child_retRdy_o,
  input  logic [CHILD-1:0][RET_DW-1:0]             child_retDin_i,
  input  logic [CHILD-1:0][LOG_PARENT-1:0]         child_parentMod_i,
  input  logic [CHILD-1:0][SEQ_W-1:0]              child_retSeq_i,
  input  logic [PARENT-1:0]                        parent_retFifo_pop_i,
  output logic [PARENT-1:0]                        parent_retFifo_empty_n_o,
  output logic [PARENT-1:0][LOG_CHILD+RET_DW-1:0]  parent_retFifo_dout_o,
  output logic                                     err_o
);

  localparam int DEPTH = 1 << SEQ_W;
  localparam int ENT_W = LOG_CHILD + RET_DW;

  // Per-child input buffer
  logic [CHILD-1:0]                 buf_vld;
  logic [CHILD-1:0][RET_DW-1:0]     buf_din;
  logic [CHILD-1:0][LOG_PARENT-1:0] buf_pm;
  logic [CHILD-1:0][SEQ_W-1:0]      buf_seq;

  // Per-parent reorder buffer and pointers
  logic [PARENT-1:0][DEPTH-1:0]     rob_vld;
  logic [ENT_W-1:0]                 rob_dat [PARENT][DEPTH];
  logic [PARENT-1:0][SEQ_W-1:0]     head;
  logic [PARENT-1:0][SEQ_W-1:0]     tail;
  logic [PARENT-1:0][SEQ_W:0]       cnt;
  logic [PARENT-1:0][LOG_CHILD-1:0] rr;
  logic                             err;

  // Arbitration results
  logic [CHILD-1:0]                 drop;
  logic [PARENT-1:0][CHILD-1:0]     elig;
  logic [PARENT-1:0]                win_vld;
  logic [PARENT-1:0][LOG_CHILD-1:0] win_idx;
  logic [PARENT-1:0][SEQ_W-1:0]     win_slot;
  logic [CHILD-1:0]                 win_clr;
  logic [PARENT-1:0]                pop_ok;

  always_comb begin
    int idx;
    idx      = 0;
    drop     = '0;
    elig     = '0;
    win_vld  = '0;
    win_idx  = '0;
    win_slot = '0;
    win_clr  = '0;
    pop_ok   = '0;

    // A destination outside the parent range can never drain, so it is discarded.
    for (int c = 0; c < CHILD; c++) begin
      drop[c] = buf_vld[c] && (int'(buf_pm[c]) >= PARENT);
    end

    // Eligibility looks only at registered ROB state, so a pop in the same
    // cycle never makes an otherwise-blocked entry writable.
    for (int p = 0; p < PARENT; p++) begin
      for (int c = 0; c < CHILD; c++) begin
        if (buf_vld[c] && (int'(buf_pm[c]) == p)) begin
          if (IN_ORDER != 0) begin
            elig[p][c] = !rob_vld[p][buf_seq[c]];
          end else begin
            elig[p][c] = (int'(cnt[p]) < DEPTH);
          end
        end
      end
    end

    // Round-robin search per parent, starting at rr[p].
    for (int p = 0; p < PARENT; p++) begin
      for (int k = 0; k < CHILD; k++) begin
        idx = (int'(rr[p]) + k) % CHILD;
        if (!win_vld[p] && elig[p][idx]) begin
          win_vld[p] = 1'b1;
          win_idx[p] = LOG_CHILD'(idx);
        end
      end
      if (win_vld[p]) begin
        win_clr[win_idx[p]] = 1'b1;
        win_slot[p] = (IN_ORDER != 0) ? buf_seq[win_idx[p]] : tail[p];
      end
      pop_ok[p] = parent_retFifo_pop_i[p] && rob_vld[p][head[p]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld <= '0;
      buf_din <= '0;
      buf_pm  <= '0;
      buf_seq <= '0;
      rob_vld <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      rr      <= '0;
      err     <= 1'b0;
      for (int p = 0; p < PARENT; p++) begin
        for (int d = 0; d < DEPTH; d++) begin
          rob_dat[p][d] <= '0;
        end
      end
    end else begin
      // Capture only into an empty buffer; a full buffer can only clear, so
      // the two branches never coincide.
      for (int c = 0; c < CHILD; c++) begin
        if (child_retVld_i[c] && !buf_vld[c]) begin
          buf_vld[c] <= 1'b1;
          buf_din[c] <= child_retDin_i[c];
          buf_pm[c]  <= child_parentMod_i[c];
          buf_seq[c] <= child_retSeq_i[c];
        end else if (drop[c] || win_clr[c]) begin
          buf_vld[c] <= 1'b0;
        end
      end

      if (|drop) begin
        err <= 1'b1;
      end

      // Pop slot and write slot are always distinct: the head is valid when
      // popped, and the write target is invalid (or the queue is not full).
      for (int p = 0; p < PARENT; p++) begin
        if (pop_ok[p]) begin
          rob_vld[p][head[p]] <= 1'b0;
          head[p]             <= head[p] + SEQ_W'(1);
        end
        if (win_vld[p]) begin
          rob_vld[p][win_slot[p]] <= 1'b1;
          rob_dat[p][win_slot[p]] <= {win_idx[p], buf_din[win_idx[p]]};
          rr[p] <= (win_idx[p] == LOG_CHILD'(CHILD - 1)) ? '0 : win_idx[p] + LOG_CHILD'(1);
          if (IN_ORDER == 0) begin
            tail[p] <= tail[p] + SEQ_W'(1);
          end
        end
        if (IN_ORDER == 0) begin
          cnt[p] <= cnt[p] + {{SEQ_W{1'b0}}, win_vld[p]} - {{SEQ_W{1'b0}}, pop_ok[p]};
        end
      end
    end
  end

  // Outputs are muxed straight from ROB registers; no input reaches them combinationally.
  always_comb begin
    parent_retFifo_empty_n_o = '0;
    parent_retFifo_dout_o    = '0;
    for (int p = 0; p < PARENT; p++) begin
      parent_retFifo_empty_n_o[p] = rob_vld[p][head[p]];
      parent_retFifo_dout_o[p]    = rob_dat[p][head[p]];
    end
  end

  assign child_retRdy_o = ~buf_vld & {CHILD{~rst}};
  assign err_o          = err;

endmodule

// File: tb/tb_return_arbiter_rob.sv
// Directed bench for return_arbiter_rob: one in-order instance (4 parents) and one
// plain-FIFO instance (3 parents, so an out-of-range destination is representable).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_return_arbiter_rob;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: IN_ORDER = 1, PARENT = 4
  logic [3:0]        a_vld, a_rdy;
  logic [3:0][31:0]  a_din;
  logic [3:0][1:0]   a_pm;
  logic [3:0][2:0]   a_seq;
  logic [3:0]        a_pop, a_en;
  logic [3:0][33:0]  a_dout;
  logic              a_err;

  // Instance B: IN_ORDER = 0, PARENT = 3
  logic [3:0]        b_vld, b_rdy;
  logic [3:0][31:0]  b_din;
  logic [3:0][1:0]   b_pm;
  logic [3:0][2:0]   b_seq;
  logic [2:0]        b_pop, b_en;
  logic [2:0][33:0]  b_dout;
  logic              b_err;

  return_arbiter_rob #(.PARENT(4), .CHILD(4), .RET_DW(32), .SEQ_W(3), .IN_ORDER(1)) dut_a (
    .clk(clk), .rst(rst),
    .child_retVld_i(a_vld), .child_retRdy_o(a_rdy), .child_retDin_i(a_din),
    .child_parentMod_i(a_pm), .child_retSeq_i(a_seq),
    .parent_retFifo_pop_i(a_pop), .parent_retFifo_empty_n_o(a_en),
    .parent_retFifo_dout_o(a_dout), .err_o(a_err)
  );

  return_arbiter_rob #(.PARENT(3), .CHILD(4), .RET_DW(32), .SEQ_W(3), .IN_ORDER(0)) dut_b (
    .clk(clk), .rst(rst),
    .child_retVld_i(b_vld), .child_retRdy_o(b_rdy), .child_retDin_i(b_din),
    .child_parentMod_i(b_pm), .child_retSeq_i(b_seq),
    .parent_retFifo_pop_i(b_pop), .parent_retFifo_empty_n_o(b_en),
    .parent_retFifo_dout_o(b_dout), .err_o(b_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] ent(input int id, input logic [31:0] v);
    logic [1:0] i2;
    i2 = id[1:0];
    return {i2, v};
  endfunction

  task automatic a_set(input int c, input logic [1:0] pm, input logic [2:0] sq, input logic [31:0] d);
    a_vld[c] = 1'b1; a_pm[c] = pm; a_seq[c] = sq; a_din[c] = d;
  endtask

  task automatic b_set(input int c, input logic [1:0] pm, input logic [31:0] d);
    b_vld[c] = 1'b1; b_pm[c] = pm; b_seq[c] = 3'd0; b_din[c] = d;
  endtask

  initial begin
    rst = 1'b1;
    a_vld = '0; a_din = '0; a_pm = '0; a_seq = '0; a_pop = '0;
    b_vld = '0; b_din = '0; b_pm = '0; b_seq = '0; b_pop = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rdy", a_rdy, 0);
    chk("rst_b_rdy", b_rdy, 0);
    chk("rst_a_en", a_en, 0);
    chk("rst_a_dout", |a_dout, 0);
    chk("rst_err", {a_err, b_err}, 0);
    rst = 1'b0;
    tick();
    chk("rel_a_rdy", a_rdy, 4'hf);
    chk("rel_b_rdy", b_rdy, 4'hf);

    // 1: out-of-order completion to parent 0, released in sequence order
    a_pop[0] = 1'b1;
    a_set(2, 2'd0, 3'd2, 32'hA2); tick();
    a_vld[2] = 1'b0; a_set(1, 2'd0, 3'd1, 32'hA1);
    chk("t1_en_e0", a_en[0], 0); tick();
    a_vld[1] = 1'b0; a_set(0, 2'd0, 3'd0, 32'hA0);
    chk("t1_en_e1", a_en[0], 0); tick();
    a_vld[0] = 1'b0;
    chk("t1_en_e2", a_en[0], 0); tick();
    chk("t1_en_e3", a_en[0], 1);
    chk("t1_d0", a_dout[0], ent(0, 32'hA0)); tick();
    chk("t1_d1", a_dout[0], ent(1, 32'hA1)); tick();
    chk("t1_d2", a_dout[0], ent(2, 32'hA2)); tick();
    chk("t1_empty", a_en[0], 0);
    a_pop[0] = 1'b0;

    // 2: two bursts of all children to parent 1; one write per cycle in rr order
    a_pop[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) a_set(c, 2'd1, 3'(4 * b + c), 32'hB0 + 32'(16 * b + c));
      tick();
      a_vld = '0;
      chk("t2_en_e0", a_en[1], 0); tick();
      for (int i = 0; i < 4; i++) begin
        chk("t2_en", a_en[1], 1);
        chk("t2_dout", a_dout[1], ent(i, 32'hB0 + 32'(16 * b + i)));
        tick();
      end
      chk("t2_empty", a_en[1], 0);
      chk("t2_rdy", a_rdy, 4'hf);
    end
    a_pop[1] = 1'b0;

    // 4: sequence lapping the window on parent 2
    a_set(0, 2'd2, 3'd3, 32'hD3); tick();
    a_vld[0] = 1'b0; tick();
    a_set(1, 2'd2, 3'd3, 32'hE3); tick();
    a_vld[1] = 1'b0; tick(); tick();
    chk("t4_stall_rdy", a_rdy[1], 0);
    chk("t4_stall_en", a_en[2], 0);
    for (int s = 0; s < 3; s++) begin
      a_set(2, 2'd2, 3'(s), 32'hD0 + 32'(s)); tick();
      a_vld[2] = 1'b0; tick();
    end
    chk("t4_head0", a_dout[2], ent(2, 32'hD0));
    a_pop[2] = 1'b1;
    tick(); chk("t4_head1", a_dout[2], ent(2, 32'hD1));
    tick(); chk("t4_head2", a_dout[2], ent(2, 32'hD2));
    tick(); chk("t4_head3", a_dout[2], ent(0, 32'hD3));
    tick();
    chk("t4_still_stalled", a_rdy[1], 0);
    chk("t4_en_h4", a_en[2], 0);
    tick();
    chk("t4_written", a_rdy[1], 1);
    a_pop[2] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_set(2, 2'd2, 3'((4 + i) % 8), 32'hF0 + 32'((4 + i) % 8)); tick();
      a_vld[2] = 1'b0; tick();
    end
    a_pop[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", a_dout[2], (i < 7) ? ent(2, 32'hF0 + 32'((4 + i) % 8)) : ent(1, 32'hE3));
      tick();
    end
    chk("t4_empty", a_en[2], 0);
    a_pop[2] = 1'b0;

    // 3: plain FIFO fills at 8 entries, further returns hold in buffers
    for (int k = 0; k < 10; k++) begin
      chk("t3_hs_rdy", b_rdy[k % 4], 1);
      b_set(k % 4, 2'd2, 32'h100 + 32'(k)); tick();
      b_vld[k % 4] = 1'b0;
    end
    tick(); tick();
    chk("t3_full_rdy0", b_rdy[0], 0);
    chk("t3_full_rdy1", b_rdy[1], 0);
    chk("t3_head", b_dout[2], ent(0, 32'h100));
    b_pop[2] = 1'b1; tick(); b_pop[2] = 1'b0;
    chk("t3_pop_head", b_dout[2], ent(1, 32'h101));
    chk("t3_no_same_cycle", b_rdy[0], 0);
    tick();
    chk("t3_one_write", b_rdy[0], 1);
    chk("t3_still_full", b_rdy[1], 0);
    tick();
    chk("t3_still_full2", b_rdy[1], 0);
    b_pop[2] = 1'b1;
    for (int k = 2; k < 10; k++) begin
      tick();
      chk("t3_drain", b_dout[2], ent(k % 4, 32'h100 + 32'(k)));
    end
    tick();
    chk("t3_empty", b_en[2], 0);
    b_pop[2] = 1'b0;

    // 5: out-of-range destination dropped, other parents unaffected
    b_set(3, 2'd3, 32'hDEAD); b_set(2, 2'd0, 32'h55); tick();
    b_vld = '0; tick();
    chk("t5_err", b_err, 1);
    chk("t5_dropped_rdy", b_rdy[3], 1);
    chk("t5_other_en", b_en, 3'b001);
    chk("t5_other_dout", b_dout[0], ent(2, 32'h55));
    tick();
    chk("t5_err_sticky", b_err, 1);
    b_pop[0] = 1'b1; tick(); b_pop[0] = 1'b0;
    chk("t5_popped", b_en[0], 0);

    // 6: reset mid-operation
    a_set(0, 2'd3, 3'd0, 32'h60); a_set(1, 2'd3, 3'd1, 32'h61); tick();
    a_vld = '0; tick(); tick();
    chk("t6_rob_en", a_en[3], 1);
    a_set(0, 2'd3, 3'd0, 32'h70); a_set(1, 2'd3, 3'd1, 32'h71); a_set(2, 2'd3, 3'd0, 32'h72); tick();
    a_vld = '0; tick();
    chk("t6_buffered", a_rdy[2:0], 3'b000);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_en", a_en, 0);
    chk("t6_rst_dout", |a_dout, 0);
    chk("t6_rst_rdy", a_rdy, 0);
    chk("t6_rst_err", b_err, 0);
    tick();
    chk("t6_rst_rdy_hold", a_rdy, 0);
    rst = 1'b0;
    tick();
    chk("t6_rel_rdy", a_rdy, 4'hf);
    chk("t6_rel_en", a_en, 0);
    a_set(3, 2'd0, 3'd0, 32'h99); tick();
    a_vld = '0; tick();
    chk("t6_fresh_en", a_en[0], 1);
    chk("t6_fresh_dout", a_dout[0], ent(3, 32'h99));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
